// File: rtl/gestor_baterias_if.sv
// Sensor/load-side bundle of the battery sequencer.
// num_cambios exists only when CONTADOR_CAMBIOS_EN is defined.
interface gestor_baterias_if;
    logic [3:0] carga_bateria1;
    logic [3:0] carga_bateria2;
    logic       sel_bateria1;
    logic       sel_bateria2;
    logic       optimo;
    logic       aceptable;
    logic       regular;
    logic       critico;
    logic       alarma;
`ifdef CONTADOR_CAMBIOS_EN
    logic [7:0] num_cambios;
`endif

    modport master (
`ifdef CONTADOR_CAMBIOS_EN
        input  num_cambios,
`endif
        output carga_bateria1,
        output carga_bateria2,
        input  sel_bateria1,
        input  sel_bateria2,
        input  optimo,
        input  aceptable,
        input  regular,
        input  critico,
        input  alarma
    );

    modport slave (
`ifdef CONTADOR_CAMBIOS_EN
        output num_cambios,
`endif
        input  carga_bateria1,
        input  carga_bateria2,
        output sel_bateria1,
        output sel_bateria2,
        output optimo,
        output aceptable,
        output regular,
        output critico,
        output alarma
    );
endinterface

// File: rtl/gestor_baterias.sv
// Two-battery sequencer: debounced charge level plus source FSM with dead time.
// Optional CONTADOR_CAMBIOS_EN adds a saturating source-change counter.
module gestor_baterias #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned HISTERESIS  = 2,
    parameter int unsigned CARGA_MIN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    gestor_baterias_if.slave bus
);
    localparam logic [3:0] HOLD  = 4'(HOLD_CYCLES);
    localparam logic [3:0] DEAD  = 4'(DEAD_CYCLES);
    localparam logic [5:0] HIST6 = 6'(HISTERESIS);
    localparam logic [5:0] MIN6  = 6'(CARGA_MIN);

    // One-hot level: {optimo, aceptable, regular, critico}
    localparam logic [3:0] N_OPT = 4'b1000;
    localparam logic [3:0] N_ACE = 4'b0100;
    localparam logic [3:0] N_REG = 4'b0010;
    localparam logic [3:0] N_CRT = 4'b0001;

    typedef enum logic [2:0] {
        APAGADO,
        CAMBIO_A_B1,
        CAMBIO_A_B2,
        USA_B1,
        USA_B2
    } estado_t;

    estado_t    est_q, est_d;
    logic [3:0] dead_q, dead_d;
    logic [3:0] nivel_q, nivel_d;
    logic [3:0] previo_q;
    logic [3:0] cnt_q, cnt_d;
    logic       alarma_q, alarma_d;
    logic [3:0] cand;
    logic [4:0] total;
    logic [5:0] b1, b2, bmax;
    logic       agot;

    assign b1    = {2'b00, bus.carga_bateria1};
    assign b2    = {2'b00, bus.carga_bateria2};
    assign total = {1'b0, bus.carga_bateria1} + {1'b0, bus.carga_bateria2};
    assign bmax  = (b1 >= b2) ? b1 : b2;
    assign agot  = (b1 < MIN6) && (b2 < MIN6);

    always_comb begin
        cand = N_CRT;
        if (total >= 5'd22)      cand = N_OPT;
        else if (total >= 5'd15) cand = N_ACE;
        else if (total >= 5'd7)  cand = N_REG;
    end

    // Count restarts whenever the candidate differs from last cycle's
    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = cnt_q + 4'd1;
        if (cand == nivel_q || cand != previo_q)
            cnt_d = (cand != nivel_q) ? 4'd1 : 4'd0;
        if (cnt_d == HOLD) begin
            nivel_d = cand;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        est_d  = est_q;
        dead_d = dead_q;
        unique case (est_q)
            APAGADO: begin
                if (bmax >= MIN6 + HIST6) begin
                    est_d  = (b1 >= b2) ? CAMBIO_A_B1 : CAMBIO_A_B2;
                    dead_d = 4'd1;
                end
            end
            USA_B1: begin
                if (agot) begin
                    est_d = APAGADO;
                end else if (b2 >= b1 + HIST6) begin
                    est_d  = CAMBIO_A_B2;
                    dead_d = 4'd1;
                end
            end
            USA_B2: begin
                if (agot) begin
                    est_d = APAGADO;
                end else if (b1 >= b2 + HIST6) begin
                    est_d  = CAMBIO_A_B1;
                    dead_d = 4'd1;
                end
            end
            CAMBIO_A_B1, CAMBIO_A_B2: begin
                if (dead_q == DEAD) begin
                    if (agot)
                        est_d = APAGADO;
                    else if (est_q == CAMBIO_A_B1)
                        est_d = USA_B1;
                    else
                        est_d = USA_B2;
                end else begin
                    dead_d = dead_q + 4'd1;
                end
            end
            default: est_d = APAGADO;
        endcase
    end

    assign alarma_d = (nivel_d == N_CRT) && (est_d == APAGADO);

    always_ff @(posedge clk) begin
        if (rst) begin
            est_q    <= APAGADO;
            dead_q   <= 4'd0;
            nivel_q  <= N_CRT;
            previo_q <= N_CRT;
            cnt_q    <= 4'd0;
            alarma_q <= 1'b1;
        end else begin
            est_q    <= est_d;
            dead_q   <= dead_d;
            nivel_q  <= nivel_d;
            previo_q <= cand;
            cnt_q    <= cnt_d;
            alarma_q <= alarma_d;
        end
    end

`ifdef CONTADOR_CAMBIOS_EN
    logic [7:0] ncamb_q;
    logic       entra;

    assign entra = (est_d == CAMBIO_A_B1 || est_d == CAMBIO_A_B2)
                && !(est_q == CAMBIO_A_B1 || est_q == CAMBIO_A_B2);

    always_ff @(posedge clk) begin
        if (rst)
            ncamb_q <= 8'd0;
        else if (entra && ncamb_q != 8'hFF)
            ncamb_q <= ncamb_q + 8'd1;
    end

    assign bus.num_cambios = ncamb_q;
`endif

    assign bus.sel_bateria1 = (est_q == USA_B1);
    assign bus.sel_bateria2 = (est_q == USA_B2);
    assign bus.optimo       = nivel_q[3];
    assign bus.aceptable    = nivel_q[2];
    assign bus.regular      = nivel_q[1];
    assign bus.critico      = nivel_q[0];
    assign bus.alarma       = alarma_q;
endmodule
